fetch_bpred: RTL and testbench
==============================

Name: fetch_bpred

Overview:
Parametrised successor to the CPU's fetch stage. It replaces "always PC+4, redirect on branch resolve" with a direct-mapped branch target buffer (BTB) and per-entry saturating counters. This lets taken branches redirect fetch in IF instead of flushing three stages. It drives the instruction memory address and presents a registered IF/ID bundle to decode, and it accepts redirect and training inputs from the branch-resolve stage.

Parameters:
XLEN, 32, width of PC, instruction and target.
BTB_ENTRIES, 16, number of BTB entries; power of two, at least 2; IDX_W = log2(BTB_ENTRIES).
CTR_BITS, 2, width of the saturating direction counter; at least 2.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst_n  in  1  reset; asynchronous, active-low.
stall  in  1  hold the PC and the IF/ID bundle (load-use stall from decode).
redirect_valid  in  1  resolve stage detected a misprediction; refetch from redirect_pc.
redirect_pc  in  XLEN  correct next PC.
upd_valid  in  1  train the BTB with one resolved branch.
upd_pc  in  XLEN  PC of the resolved branch.
upd_taken  in  1  resolved direction.
upd_target  in  XLEN  resolved target.
imem_addr  out  XLEN  current PC, combinational to instruction memory.
imem_data  in  XLEN  instruction at imem_addr, same cycle.
if_valid  out  1  IF/ID bundle valid.
if_pc  out  XLEN  PC of the bundled instruction.
if_pc4  out  XLEN  if_pc + 4.
if_inst  out  XLEN  bundled instruction.
if_pred_taken  out  1  fetch predicted taken.
if_pred_target  out  XLEN  predicted target; 0 when not taken.

Behaviour:
- Reset (asynchronous, rst_n = 0):
  - pc = RESET_PC.
  - All BTB valid bits = 0.
  - if_valid = 0 and every other if_* output = 0.
  - Counters and tags are don't-care.
  - Deassertion is sampled synchronously. The first fetch is at RESET_PC in the cycle after rst_n rises.
- Lookup (combinational on pc):
  - idx = pc[IDX_W+1:2], tag = pc[XLEN-1:IDX_W+2]; pc[1:0] is ignored.
  - hit = valid[idx] && tag match.
  - pred_taken = hit && ctr[idx] MSB = 1.
- Next PC, by priority:
  1. redirect_valid: pc <= redirect_pc.
  2. stall: pc holds.
  3. pred_taken: pc <= BTB target.
  4. Otherwise: pc <= pc + 4, wrapping modulo 2^XLEN.
- Redirect overrides stall in the same cycle.
- IF/ID register, one-cycle latency from imem_addr:
  - redirect_valid: if_valid <= 0 (flush); other fields are don't-care.
  - Else stall: all if_* fields hold.
  - Else: if_valid <= 1 and the fields load pc, pc+4, imem_data, pred_taken, and the target (or 0 when not taken).
- Training (upd_valid), uidx and utag derived from upd_pc:
  - Hit, taken: counter increments and saturates at 2^CTR_BITS-1; target <= upd_target.
  - Hit, not taken: counter decrements and saturates at 0; target is unchanged.
  - Miss, taken: allocate the entry, overwriting any previous entry. valid=1, tag=utag, target=upd_target, counter = weakly taken (MSB=1, all other bits 0).
  - Miss, not taken: no change.
- Training is independent of stall and redirect, and is applied in the same cycle as them.
- Same-cycle lookup and update on the same index: the lookup sees the pre-update contents. The write takes effect at the clock edge.
- Training on a PC that aliases the fetch index with a different tag replaces the entry (direct-mapped, no replacement policy).
- No state machine beyond PC, the IF/ID register and the BTB arrays. The BTB is a flop array: no read latency, no SRAM.

Optional Feature:
BPRED_STATS_EN:
- When defined, adds output ports stat_branches (32) and stat_mispredicts (32), both saturating counters reset to 0.
  - stat_branches increments on each upd_valid.
  - stat_mispredicts increments on each redirect_valid.
  - Counters hold at all-ones.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- Shared package cpu_pkg holds:
  - the BTB entry typedef {valid, tag, target, ctr};
  - counter constants CTR_MAX and CTR_WEAK_TAKEN;
  - the existing BRANCH_BEQ/BRANCH_BNE encodings, which the resolve stage uses to generate upd_*.
- One sub-module, btb: storage, combinational lookup port, synchronous training port and reset of valid bits.
- fetch_bpred owns the PC, next-PC mux and IF/ID register.

Test Plan:
- Reset then free run, RESET_PC=0, no updates -> imem_addr 0,4,8,12 on successive cycles; if_valid first 1 one cycle after the first fetch; if_pred_taken always 0.
- upd_valid, upd_pc=0x10, upd_taken=1, upd_target=0x40, then fetch reaches 0x10 -> next imem_addr=0x40; if_pred_taken=1; if_pred_target=0x40.
- Counter hysteresis, CTR_BITS=2, entry starting at 2'b10:
  - one not-taken update -> counter 01 and fetch at 0x10 falls through to 0x14;
  - two taken updates -> counter 11 (saturated);
  - one not-taken update -> counter 10, still predicts taken.
- stall and redirect_valid both asserted with redirect_pc=0x100 -> next imem_addr=0x100 and if_valid=0 next cycle; stall alone for 3 cycles -> pc and every if_* field held.
- Alias test, BTB_ENTRIES=16: train 0x10 taken to 0x40, then train 0x50 taken to 0x80 (same idx, different tag) -> fetch at 0x10 falls through to 0x14; fetch at 0x50 goes to 0x80.
- Same-cycle collision: fetch pc=0x10 while allocating 0x10 -> this fetch predicts not-taken; the next fetch at 0x10 predicts taken. With BPRED_STATS_EN, the counters match the injected upd_valid and redirect counts.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: BTB entry layout, direction-counter constants and branch encodings.
// The optional BPRED_STATS_EN build of fetch_bpred uses nothing extra from here.
package cpu_pkg;

  localparam int CPU_XLEN     = 32;
  localparam int CPU_IDX_W    = 4;
  localparam int CPU_CTR_BITS = 2;

  localparam logic [CPU_CTR_BITS-1:0] CTR_MAX        = '1;
  localparam logic [CPU_CTR_BITS-1:0] CTR_WEAK_TAKEN = {1'b1, {(CPU_CTR_BITS-1){1'b0}}};

  // funct3 encodings consumed by the resolve stage when it generates upd_*
  localparam logic [2:0] BRANCH_BEQ = 3'b000;
  localparam logic [2:0] BRANCH_BNE = 3'b001;

  typedef struct packed {
    logic                                valid;
    logic [CPU_XLEN-CPU_IDX_W-3:0]       tag;
    logic [CPU_XLEN-1:0]                 target;
    logic [CPU_CTR_BITS-1:0]             ctr;
  } btb_entry_t;

  // Width-generic forms of the counter constants for parametrised counters
  function automatic int unsigned ctr_max_val(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

  function automatic int unsigned ctr_weak_taken_val(input int unsigned bits);
    return 32'd1 << (bits - 32'd1);
  endfunction

endpackage

// File: rtl/fetch_bpred_btb.sv
// Direct-mapped branch target buffer: flop storage, combinational lookup, synchronous training.
// Addresses arrive as word addresses (pc[XLEN-1:2]); only valid bits are reset.
module btb
  import cpu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BTB_ENTRIES = 16,
  parameter int CTR_BITS    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [XLEN-3:0] lk_word,
  output logic            lk_taken,
  output logic [XLEN-1:0] lk_target,
  input  logic            upd_valid,
  input  logic [XLEN-3:0] upd_word,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target
);

  localparam int IDX_W = $clog2(BTB_ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CTR_BITS-1:0] CTR_SAT = CTR_BITS'(ctr_max_val(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_WT  = CTR_BITS'(ctr_weak_taken_val(CTR_BITS));

  logic [BTB_ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]       tag_q    [BTB_ENTRIES];
  logic [TAG_W-1:0]       tag_d    [BTB_ENTRIES];
  logic [XLEN-1:0]        target_q [BTB_ENTRIES];
  logic [XLEN-1:0]        target_d [BTB_ENTRIES];
  logic [CTR_BITS-1:0]    ctr_q    [BTB_ENTRIES];
  logic [CTR_BITS-1:0]    ctr_d    [BTB_ENTRIES];

  logic [IDX_W-1:0] lk_idx, u_idx;
  logic [TAG_W-1:0] lk_tag, u_tag;
  logic             u_hit;

  function automatic logic [CTR_BITS-1:0] ctr_inc(input logic [CTR_BITS-1:0] c);
    return (c == CTR_SAT) ? c : c + 1'b1;
  endfunction

  function automatic logic [CTR_BITS-1:0] ctr_dec(input logic [CTR_BITS-1:0] c);
    return (c == '0) ? c : c - 1'b1;
  endfunction

  assign lk_idx    = lk_word[IDX_W-1:0];
  assign lk_tag    = lk_word[XLEN-3:IDX_W];
  assign lk_taken  = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && ctr_q[lk_idx][CTR_BITS-1];
  assign lk_target = target_q[lk_idx];

  assign u_idx = upd_word[IDX_W-1:0];
  assign u_tag = upd_word[XLEN-3:IDX_W];
  assign u_hit = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  always_comb begin
    valid_d = valid_q;
    for (int i = 0; i < BTB_ENTRIES; i++) begin
      tag_d[i]    = tag_q[i];
      target_d[i] = target_q[i];
      ctr_d[i]    = ctr_q[i];
    end
    if (upd_valid) begin
      if (u_hit) begin
        if (upd_taken) begin
          ctr_d[u_idx]    = ctr_inc(ctr_q[u_idx]);
          target_d[u_idx] = upd_target;
        end else begin
          ctr_d[u_idx]    = ctr_dec(ctr_q[u_idx]);
        end
      end else if (upd_taken) begin
        // Miss-taken overwrites whatever lived at this index
        valid_d[u_idx]  = 1'b1;
        tag_d[u_idx]    = u_tag;
        target_d[u_idx] = upd_target;
        ctr_d[u_idx]    = CTR_WT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  always_ff @(posedge clk) begin
    tag_q    <= tag_d;
    target_q <= target_d;
    ctr_q    <= ctr_d;
  end

endmodule

// File: rtl/fetch_bpred.sv
// Fetch stage with BTB-based next-PC prediction and a registered IF/ID bundle.
// Define BPRED_STATS_EN to add saturating branch/mispredict counters.
module fetch_bpred
  import cpu_pkg::*;
#(
  parameter int              XLEN        = 32,
  parameter int              BTB_ENTRIES = 16,
  parameter int              CTR_BITS    = 2,
  parameter logic [XLEN-1:0] RESET_PC    = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            upd_valid,
  input  logic [XLEN-1:0] upd_pc,
  input  logic            upd_taken,
  input  logic [XLEN-1:0] upd_target,
  output logic [XLEN-1:0] imem_addr,
  input  logic [XLEN-1:0] imem_data,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc4,
  output logic [XLEN-1:0] if_inst,
  output logic            if_pred_taken,
  output logic [XLEN-1:0] if_pred_target
`ifdef BPRED_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispredicts
`endif
);

  logic [XLEN-1:0] pc_q, pc_d, pc_plus4;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_pc4_q, if_pc4_d;
  logic [XLEN-1:0] if_inst_q, if_inst_d;
  logic            if_pred_taken_q, if_pred_taken_d;
  logic [XLEN-1:0] if_pred_target_q, if_pred_target_d;
  logic            bp_taken;
  logic [XLEN-1:0] bp_target;
  logic [1:0]      unused_upd_lsb;

  assign unused_upd_lsb = upd_pc[1:0];
  assign pc_plus4       = pc_q + XLEN'(4);
  assign imem_addr      = pc_q;

  btb #(
    .XLEN        (XLEN),
    .BTB_ENTRIES (BTB_ENTRIES),
    .CTR_BITS    (CTR_BITS)
  ) u_btb (
    .clk        (clk),
    .rst_n      (rst_n),
    .lk_word    (pc_q[XLEN-1:2]),
    .lk_taken   (bp_taken),
    .lk_target  (bp_target),
    .upd_valid  (upd_valid),
    .upd_word   (upd_pc[XLEN-1:2]),
    .upd_taken  (upd_taken),
    .upd_target (upd_target)
  );

  always_comb begin
    pc_d             = pc_q;
    if_valid_d       = if_valid_q;
    if_pc_d          = if_pc_q;
    if_pc4_d         = if_pc4_q;
    if_inst_d        = if_inst_q;
    if_pred_taken_d  = if_pred_taken_q;
    if_pred_target_d = if_pred_target_q;
    // Redirect wins over stall: a mispredict must flush even a stalled bundle
    if (redirect_valid) begin
      pc_d       = redirect_pc;
      if_valid_d = 1'b0;
    end else if (!stall) begin
      pc_d             = bp_taken ? bp_target : pc_plus4;
      if_valid_d       = 1'b1;
      if_pc_d          = pc_q;
      if_pc4_d         = pc_plus4;
      if_inst_d        = imem_data;
      if_pred_taken_d  = bp_taken;
      if_pred_target_d = bp_taken ? bp_target : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q             <= RESET_PC;
      if_valid_q       <= 1'b0;
      if_pc_q          <= '0;
      if_pc4_q         <= '0;
      if_inst_q        <= '0;
      if_pred_taken_q  <= 1'b0;
      if_pred_target_q <= '0;
    end else begin
      pc_q             <= pc_d;
      if_valid_q       <= if_valid_d;
      if_pc_q          <= if_pc_d;
      if_pc4_q         <= if_pc4_d;
      if_inst_q        <= if_inst_d;
      if_pred_taken_q  <= if_pred_taken_d;
      if_pred_target_q <= if_pred_target_d;
    end
  end

  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_pc4         = if_pc4_q;
  assign if_inst        = if_inst_q;
  assign if_pred_taken  = if_pred_taken_q;
  assign if_pred_target = if_pred_target_q;

`ifdef BPRED_STATS_EN
  logic [31:0] stat_branches_q, stat_branches_d;
  logic [31:0] stat_mispredicts_q, stat_mispredicts_d;

  always_comb begin
    stat_branches_d    = stat_branches_q;
    stat_mispredicts_d = stat_mispredicts_q;
    if (upd_valid && (stat_branches_q != '1))         stat_branches_d    = stat_branches_q + 32'd1;
    if (redirect_valid && (stat_mispredicts_q != '1)) stat_mispredicts_d = stat_mispredicts_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_fetch_bpred.sv
// Directed bench for fetch_bpred with a cycle-level reference model of fetch and the BTB.
module tb_fetch_bpred;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, redirect_valid, upd_valid, upd_taken;
  logic [31:0] redirect_pc, upd_pc, upd_target;
  logic [31:0] imem_addr, imem_data;
  logic        if_valid, if_pred_taken;
  logic [31:0] if_pc, if_pc4, if_inst, if_pred_target;
`ifdef BPRED_STATS_EN
  logic [31:0] stat_branches, stat_mispredicts;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int n_upd   = 0;
  int n_redir = 0;

  // Reference state: plain integers and small arrays
  int unsigned m_pc;
  bit          m_v   [16];
  int unsigned m_tag [16];
  int unsigned m_tgt [16];
  int          m_ctr [16];
  bit          m_ifv, m_ifpt;
  int unsigned m_ifpc, m_ifpc4, m_ifinst, m_iftgt;

  fetch_bpred dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .upd_valid      (upd_valid),
    .upd_pc         (upd_pc),
    .upd_taken      (upd_taken),
    .upd_target     (upd_target),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .if_valid       (if_valid),
    .if_pc          (if_pc),
    .if_pc4         (if_pc4),
    .if_inst        (if_inst),
    .if_pred_taken  (if_pred_taken),
    .if_pred_target (if_pred_target)
`ifdef BPRED_STATS_EN
    ,
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0000_1234;
  endfunction

  assign imem_data = inst_of(imem_addr);

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 0;
    for (int i = 0; i < 16; i++) begin
      m_v[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 0;
    end
    m_ifv = 0; m_ifpt = 0; m_ifpc = 0; m_ifpc4 = 0; m_ifinst = 0; m_iftgt = 0;
  endtask

  // Advance the model by one clock using the inputs currently applied
  task automatic model_step();
    int unsigned idx, tg, ui, ut, nxt;
    bit          pt;
    idx = (m_pc >> 2) % 16;
    tg  = m_pc >> 6;
    pt  = m_v[idx] && (m_tag[idx] == tg) && (m_ctr[idx] >= 2);
    nxt = m_pc;
    if (redirect_valid) begin
      nxt   = redirect_pc;
      m_ifv = 0;
    end else if (!stall) begin
      nxt      = pt ? m_tgt[idx] : m_pc + 4;
      m_ifv    = 1;
      m_ifpc   = m_pc;
      m_ifpc4  = m_pc + 4;
      m_ifinst = inst_of(m_pc);
      m_ifpt   = pt;
      m_iftgt  = pt ? m_tgt[idx] : 0;
    end
    if (upd_valid) begin
      ui = (upd_pc >> 2) % 16;
      ut = upd_pc >> 6;
      if (m_v[ui] && m_tag[ui] == ut) begin
        if (upd_taken) begin
          m_ctr[ui] = (m_ctr[ui] < 3) ? m_ctr[ui] + 1 : 3;
          m_tgt[ui] = upd_target;
        end else begin
          m_ctr[ui] = (m_ctr[ui] > 0) ? m_ctr[ui] - 1 : 0;
        end
      end else if (upd_taken) begin
        m_v[ui] = 1; m_tag[ui] = ut; m_tgt[ui] = upd_target; m_ctr[ui] = 2;
      end
    end
    m_pc = nxt;
  endtask

  task automatic compare_model();
    chk("imem_addr", imem_addr, m_pc);
    chk("if_valid", {31'd0, if_valid}, {31'd0, m_ifv});
    if (m_ifv) begin
      chk("if_pc", if_pc, m_ifpc);
      chk("if_pc4", if_pc4, m_ifpc4);
      chk("if_inst", if_inst, m_ifinst);
      chk("if_pred_taken", {31'd0, if_pred_taken}, {31'd0, m_ifpt});
      chk("if_pred_target", if_pred_target, m_iftgt);
    end
  endtask

  // Called just after a falling edge with this cycle's inputs applied
  task automatic tick();
    #1;
    compare_model();
    if (upd_valid) n_upd++;
    if (redirect_valid) n_redir++;
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    stall = 0; redirect_valid = 0; redirect_pc = 0;
    upd_valid = 0; upd_pc = 0; upd_taken = 0; upd_target = 0;
  endtask

  task automatic redirect_to(input logic [31:0] a);
    redirect_valid = 1; redirect_pc = a;
    tick();
    redirect_valid = 0;
    tick();
  endtask

  task automatic train(input logic [31:0] p, input logic t, input logic [31:0] tgt);
    upd_valid = 1; upd_pc = p; upd_taken = t; upd_target = tgt;
    tick();
    upd_valid = 0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_addr"}, imem_addr, 32'h0);
    chk({tag, "_valid"}, {31'd0, if_valid}, 32'd0);
    chk({tag, "_pc"}, if_pc, 32'h0);
    chk({tag, "_pc4"}, if_pc4, 32'h0);
    chk({tag, "_inst"}, if_inst, 32'h0);
    chk({tag, "_pt"}, {31'd0, if_pred_taken}, 32'd0);
    chk({tag, "_ptgt"}, if_pred_target, 32'h0);
  endtask

  initial begin
    idle_inputs();
    rst_n = 0;
    model_reset();
    @(negedge clk); @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1;

    // Free run from RESET_PC
    chk("first_fetch", imem_addr, 32'h0);
    tick();
    chk("run_pc4", imem_addr, 32'h4);
    chk("run_valid", {31'd0, if_valid}, 32'd1);
    chk("run_ifpc", if_pc, 32'h0);
    tick();
    chk("run_pc8", imem_addr, 32'h8);
    tick();
    chk("run_pc12", imem_addr, 32'hC);

    // Allocate 0x10 -> 0x40, then fetch reaches 0x10
    train(32'h10, 1, 32'h40);
    chk("at_0x10", imem_addr, 32'h10);
    tick();
    chk("pred_addr", imem_addr, 32'h40);
    chk("pred_taken", {31'd0, if_pred_taken}, 32'd1);
    chk("pred_target", if_pred_target, 32'h40);

    // Hysteresis: 10 -> 01 falls through
    train(32'h10, 0, 32'h0);
    redirect_to(32'h10);
    chk("hyst_fall", imem_addr, 32'h14);
    chk("hyst_fall_pt", {31'd0, if_pred_taken}, 32'd0);
    train(32'h10, 1, 32'h40);
    train(32'h10, 1, 32'h40);
    train(32'h10, 0, 32'h0);
    redirect_to(32'h10);
    chk("hyst_taken", imem_addr, 32'h40);
    chk("hyst_taken_pt", {31'd0, if_pred_taken}, 32'd1);

    // Counter floors at 0: three not-taken then one taken still falls through
    train(32'h10, 0, 32'h0);
    train(32'h10, 0, 32'h0);
    train(32'h10, 0, 32'h0);
    train(32'h10, 1, 32'h40);
    redirect_to(32'h10);
    chk("floor_fall", imem_addr, 32'h14);

    // Redirect beats stall, then a three-cycle stall holds everything
    stall = 1; redirect_valid = 1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 0;
    chk("redir_addr", imem_addr, 32'h100);
    chk("redir_flush", {31'd0, if_valid}, 32'd0);
    stall = 0;
    tick();
    stall = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", imem_addr, 32'h104);
      chk("stall_ifpc", if_pc, 32'h100);
      chk("stall_inst", if_inst, inst_of(32'h100));
    end
    stall = 0;
    tick();

    // Alias: 0x50 shares index 4 with 0x10
    train(32'h10, 1, 32'h40);
    train(32'h50, 1, 32'h80);
    redirect_to(32'h10);
    chk("alias_old", imem_addr, 32'h14);
    redirect_to(32'h50);
    chk("alias_new", imem_addr, 32'h80);

    // Same-cycle collision: lookup sees the pre-update entry
    redirect_valid = 1; redirect_pc = 32'h10;
    tick();
    redirect_valid = 0;
    train(32'h10, 1, 32'h40);
    chk("coll_first", imem_addr, 32'h14);
    chk("coll_first_pt", {31'd0, if_pred_taken}, 32'd0);
    redirect_to(32'h10);
    chk("coll_second", imem_addr, 32'h40);

    // PC wraps modulo 2^32
    redirect_to(32'hFFFF_FFFC);
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc4", if_pc4, 32'h0);
    tick();
    tick();

`ifdef BPRED_STATS_EN
    #1;
    chk("stat_branches", stat_branches, n_upd);
    chk("stat_mispredicts", stat_mispredicts, n_redir);
`endif

    // Asynchronous reset mid-cycle clears state without a clock edge
    #2;
    rst_n = 0;
    #1;
    chk_reset_outputs("areset");
    model_reset();
    @(negedge clk);
    rst_n = 1;
    tick();
    redirect_to(32'h10);
    chk("post_reset_miss", imem_addr, 32'h14);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
